// File: rtl/isr_pkg.sv
// Shared PIO definitions: datapath width, counter width and the 5-bit
// count field decode used by the ISR, OSR and autopull logic.
package isr_pkg;

    localparam int ISR_WIDTH = 32;
    localparam int CNT_WIDTH = 6;

    // Occupancy of the one-entry push holding register
    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_e;

    // A 5-bit count field encodes 1..31 directly and 32 as zero
    function automatic logic [CNT_WIDTH-1:0] count_decode(input logic [4:0] field);
        return (field == 5'd0) ? 6'd32 : {1'b0, field};
    endfunction

endpackage

// File: rtl/isr_shifter.sv
// Combinational IN datapath: merges n source bits into the ISR and
// advances the saturating shift counter.
module isr_shifter
    import isr_pkg::*;
(
    input  logic [ISR_WIDTH-1:0] isr,
    input  logic [ISR_WIDTH-1:0] in_data,
    input  logic [CNT_WIDTH-1:0] n,
    input  logic [CNT_WIDTH-1:0] count,
    input  logic                 dir,
    output logic [ISR_WIDTH-1:0] isr_next,
    output logic [CNT_WIDTH-1:0] count_next
);

    logic [ISR_WIDTH-1:0] in_masked;
    logic [CNT_WIDTH:0]   count_sum;

    // Shifts of 32 rely on SV shift semantics yielding zero, so n=32 needs no special case
    always_comb begin
        in_masked  = in_data & ~({ISR_WIDTH{1'b1}} << n);
        if (dir) begin
            isr_next = (isr >> n) | (in_masked << (6'd32 - n));
        end else begin
            isr_next = (isr << n) | in_masked;
        end
        count_sum  = {1'b0, count} + {1'b0, n};
        count_next = (count_sum > 7'd32) ? 6'd32 : count_sum[CNT_WIDTH-1:0];
    end

endmodule

// File: rtl/isr.sv
// PIO input shift register: collects IN bits, loads on MOV ISR and hands
// finished words to the RX FIFO through a one-entry holding register.
module isr
    import isr_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 penable,
    input  logic                 restart,
    input  logic                 in_op,
    input  logic [ISR_WIDTH-1:0] in_data,
    input  logic [4:0]           shift,
    input  logic                 dir,
    input  logic                 autopush,
    input  logic [4:0]           thresh,
    input  logic                 push_op,
    input  logic                 push_iffull,
    input  logic                 push_block,
    input  logic                 set,
    input  logic [ISR_WIDTH-1:0] din,
    output logic                 push_valid,
    output logic [ISR_WIDTH-1:0] push_data,
    input  logic                 push_ready,
    output logic                 stall,
    output logic                 rx_overflow,
    output logic [ISR_WIDTH-1:0] dout,
    output logic [CNT_WIDTH-1:0] shift_count
);

    logic [ISR_WIDTH-1:0] isr_q, isr_d;
    logic [ISR_WIDTH-1:0] push_data_q, push_data_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 rx_overflow_q, rx_overflow_d;
    hold_state_e          state_q, state_d;

    logic [CNT_WIDTH-1:0] n;
    logic [CNT_WIDTH-1:0] thr;
    logic [ISR_WIDTH-1:0] isr_shifted;
    logic [CNT_WIDTH-1:0] count_shifted;
    logic                 slot_free;
    logic                 instr_live;
    logic                 in_autopush;
    logic                 push_eligible;
    logic                 push_load;

    isr_shifter u_shifter (
        .isr        (isr_q),
        .in_data    (in_data),
        .n          (n),
        .count      (count_q),
        .dir        (dir),
        .isr_next   (isr_shifted),
        .count_next (count_shifted)
    );

    // Decode counts and decide whether the current instruction must stall
    always_comb begin
        n             = count_decode(shift);
        thr           = count_decode(thresh);
        slot_free     = (state_q == HOLD_EMPTY) || push_ready;
        instr_live    = penable && !reset && !restart && !set;
        in_autopush   = autopush && (count_shifted >= thr);
        push_eligible = !push_iffull || (count_q >= thr);
        stall         = 1'b0;
        if (instr_live && !slot_free) begin
            if (in_op) begin
                stall = in_autopush;
            end else if (push_op) begin
                stall = push_eligible && push_block;
            end
        end
    end

    // Instruction-side datapath: restart, MOV load, IN with autopush, explicit PUSH
    always_comb begin
        isr_d         = isr_q;
        count_d       = count_q;
        push_data_d   = push_data_q;
        rx_overflow_d = 1'b0;
        push_load     = 1'b0;
        if (restart) begin
            count_d = '0;
        end else if (penable && !stall) begin
            if (set) begin
                isr_d   = din;
                count_d = '0;
            end else if (in_op) begin
                if (in_autopush) begin
                    push_data_d = isr_shifted;
                    push_load   = 1'b1;
                    isr_d       = '0;
                    count_d     = '0;
                end else begin
                    isr_d   = isr_shifted;
                    count_d = count_shifted;
                end
            end else if (push_op && push_eligible) begin
                isr_d   = '0;
                count_d = '0;
                if (slot_free) begin
                    push_data_d = isr_q;
                    push_load   = 1'b1;
                end else begin
                    rx_overflow_d = 1'b1;
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            isr_q         <= '0;
            count_q       <= '0;
            push_data_q   <= '0;
            rx_overflow_q <= 1'b0;
        end else begin
            isr_q         <= isr_d;
            count_q       <= count_d;
            push_data_q   <= push_data_d;
            rx_overflow_q <= rx_overflow_d;
        end
    end

    // Holding register occupancy state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= HOLD_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A reload in the same cycle as a drain keeps the slot full with no bubble
    always_comb begin
        state_d = state_q;
        case (state_q)
            HOLD_EMPTY: if (push_load) state_d = HOLD_FULL;
            HOLD_FULL:  if (push_ready && !push_load) state_d = HOLD_EMPTY;
            default:    state_d = HOLD_EMPTY;
        endcase
    end

    // Handshake and observation outputs
    always_comb begin
        push_valid  = (state_q == HOLD_FULL);
        push_data   = push_data_q;
        rx_overflow = rx_overflow_q;
        dout        = isr_q;
        shift_count = count_q;
    end

endmodule

// File: tb/tb_isr.sv
// Randomized and directed bench for the ISR with a word-level reference
// model and a scoreboard of words expected on the RX FIFO handshake.
module tb_isr;

    logic        clk;
    logic        reset;
    logic        penable;
    logic        restart;
    logic        in_op;
    logic [31:0] in_data;
    logic [4:0]  shift;
    logic        dir;
    logic        autopush;
    logic [4:0]  thresh;
    logic        push_op;
    logic        push_iffull;
    logic        push_block;
    logic        set;
    logic [31:0] din;
    logic        push_valid;
    logic [31:0] push_data;
    logic        push_ready;
    logic        stall;
    logic        rx_overflow;
    logic [31:0] dout;
    logic [5:0]  shift_count;

    int          total_checks = 0;
    int          bad_checks = 0;

    logic [31:0] m_isr;
    int          m_cnt;
    bit          m_hv;
    logic [31:0] m_hd;
    bit          exp_ovf;
    bit          last_stall;
    logic [31:0] exp_q[$];

    isr dut (
        .clk         (clk),
        .reset       (reset),
        .penable     (penable),
        .restart     (restart),
        .in_op       (in_op),
        .in_data     (in_data),
        .shift       (shift),
        .dir         (dir),
        .autopush    (autopush),
        .thresh      (thresh),
        .push_op     (push_op),
        .push_iffull (push_iffull),
        .push_block  (push_block),
        .set         (set),
        .din         (din),
        .push_valid  (push_valid),
        .push_data   (push_data),
        .push_ready  (push_ready),
        .stall       (stall),
        .rx_overflow (rx_overflow),
        .dout        (dout),
        .shift_count (shift_count)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got 0x%08h want 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int field_value(input logic [4:0] f);
        return (f == 5'd0) ? 32 : int'(f);
    endfunction

    // Shift expressed as arithmetic on 2^n: left multiplies, right divides
    function automatic logic [31:0] shifted_word(input logic [31:0] cur, input logic [31:0] src,
                                                 input int n, input bit right);
        longint unsigned pow;
        longint unsigned low;
        longint unsigned r;
        pow = 64'd1 << n;
        low = longint'(src) % pow;
        if (!right) r = (longint'(cur) * pow + low) % (64'd1 << 32);
        else        r = (longint'(cur) / pow) + low * ((64'd1 << 32) / pow);
        return r[31:0];
    endfunction

    function automatic int sat_count(input int c, input int n);
        return (c + n > 32) ? 32 : c + n;
    endfunction

    function automatic bit model_stall();
        int n;
        int thr;
        n   = field_value(shift);
        thr = field_value(thresh);
        if (reset || !penable || restart || set) return 1'b0;
        if (!m_hv || push_ready) return 1'b0;
        if (in_op) return autopush && (sat_count(m_cnt, n) >= thr);
        if (push_op) return push_block && (!push_iffull || m_cnt >= thr);
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_isr   = '0;
        m_cnt   = 0;
        m_hv    = 1'b0;
        m_hd    = '0;
        exp_ovf = 1'b0;
        exp_q.delete();
    endtask

    // Advance the reference model by one clock using the inputs in effect at the edge
    task automatic model_edge(input bit st);
        bit          load;
        bit          drained;
        logic [31:0] word;
        int          n;
        int          thr;
        load    = 1'b0;
        word    = '0;
        exp_ovf = 1'b0;
        drained = m_hv && push_ready;
        n       = field_value(shift);
        thr     = field_value(thresh);
        if (restart) begin
            m_cnt = 0;
        end else if (penable && !st) begin
            if (set) begin
                m_isr = din;
                m_cnt = 0;
            end else if (in_op) begin
                if (autopush && sat_count(m_cnt, n) >= thr) begin
                    load  = 1'b1;
                    word  = shifted_word(m_isr, in_data, n, dir);
                    m_isr = '0;
                    m_cnt = 0;
                end else begin
                    m_isr = shifted_word(m_isr, in_data, n, dir);
                    m_cnt = sat_count(m_cnt, n);
                end
            end else if (push_op && (!push_iffull || m_cnt >= thr)) begin
                if (!m_hv || push_ready) begin
                    load = 1'b1;
                    word = m_isr;
                end else begin
                    exp_ovf = 1'b1;
                end
                m_isr = '0;
                m_cnt = 0;
            end
        end
        if (load) begin
            m_hv = 1'b1;
            m_hd = word;
            exp_q.push_back(word);
        end else if (drained) begin
            m_hv = 1'b0;
        end
    endtask

    // Called right after a falling edge with inputs already driven
    task automatic apply_stimulus();
        bit st;
        #1;
        st         = model_stall();
        last_stall = stall;
        check_output("stall", {31'd0, stall}, {31'd0, st});
        @(posedge clk);
        model_edge(st);
        #1;
        check_output("dout", dout, m_isr);
        check_output("shift_count", {26'd0, shift_count}, m_cnt[31:0]);
        check_output("push_valid", {31'd0, push_valid}, {31'd0, m_hv});
        if (m_hv) check_output("push_data_held", push_data, m_hd);
        check_output("rx_overflow", {31'd0, rx_overflow}, {31'd0, exp_ovf});
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        restart     = 1'b0;
        in_op       = 1'b0;
        push_op     = 1'b0;
        set         = 1'b0;
        push_iffull = 1'b0;
        push_block  = 1'b0;
    endtask

    task automatic do_in(input logic [4:0] s, input logic [31:0] d);
        idle_inputs();
        in_op   = 1'b1;
        shift   = s;
        in_data = d;
        apply_stimulus();
    endtask

    task automatic do_set(input logic [31:0] d);
        idle_inputs();
        set = 1'b1;
        din = d;
        apply_stimulus();
    endtask

    // Monitor: every accepted handshake must deliver the oldest expected word
    initial begin
        logic [31:0] w;
        forever begin
            @(negedge clk);
            #4;
            if (!reset && push_valid && push_ready) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_push", push_data, 32'hxxxxxxxx);
                end else begin
                    w = exp_q.pop_front();
                    check_output("push_word", push_data, w);
                end
            end
        end
    end

    // Directed scenarios followed by a randomized run
    initial begin
        reset = 1'b1; penable = 1'b1; restart = 1'b0; in_op = 1'b0; in_data = '0;
        shift = 5'd8; dir = 1'b0; autopush = 1'b0; thresh = 5'd0; push_op = 1'b0;
        push_iffull = 1'b0; push_block = 1'b0; set = 1'b0; din = '0; push_ready = 1'b1;
        model_reset();
        last_stall = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset_dout", dout, 32'd0);
        check_output("reset_count", {26'd0, shift_count}, 32'd0);
        check_output("reset_valid", {31'd0, push_valid}, 32'd0);
        check_output("reset_ovf", {31'd0, rx_overflow}, 32'd0);
        reset = 1'b0;

        do_in(5'd8, 32'hA5);
        do_in(5'd8, 32'h3C);
        check_output("left_two_in", dout, 32'h0000A53C);
        check_output("left_count", {26'd0, shift_count}, 32'd16);

        dir = 1'b1;
        repeat (8) do_in(5'd4, 32'hF);
        check_output("right_fill", dout, 32'hFFFFFFFF);
        check_output("right_count", {26'd0, shift_count}, 32'd32);
        do_in(5'd4, 32'hF);
        check_output("count_saturate", {26'd0, shift_count}, 32'd32);

        dir = 1'b0;
        do_set(32'd0);
        autopush = 1'b1; thresh = 5'd16; push_ready = 1'b1;
        do_in(5'd8, 32'h12);
        do_in(5'd8, 32'h34);
        check_output("autopush_valid", {31'd0, push_valid}, 32'd1);
        check_output("autopush_data", push_data, 32'h1234);
        check_output("autopush_clear", dout, 32'd0);
        idle_inputs();
        apply_stimulus();

        push_ready = 1'b0;
        do_in(5'd8, 32'h56);
        do_in(5'd8, 32'h78);
        do_in(5'd8, 32'h9A);
        do_in(5'd8, 32'hBC);
        check_output("autopush_stall", {31'd0, last_stall}, 32'd1);
        check_output("stall_isr_kept", dout, 32'h9A);
        check_output("stall_count_kept", {26'd0, shift_count}, 32'd8);
        push_ready = 1'b1;
        do_in(5'd8, 32'hBC);
        check_output("stall_release", {31'd0, last_stall}, 32'd0);
        check_output("reload_data", push_data, 32'h9ABC);
        check_output("reload_valid", {31'd0, push_valid}, 32'd1);

        push_ready = 1'b0;
        autopush = 1'b0;
        do_set(32'hDEADBEEF);
        idle_inputs();
        push_op = 1'b1;
        apply_stimulus();
        check_output("overflow_pulse", {31'd0, rx_overflow}, 32'd1);
        check_output("overflow_isr_clear", dout, 32'd0);
        check_output("overflow_data_kept", push_data, 32'h9ABC);
        idle_inputs();
        apply_stimulus();
        check_output("overflow_one_cycle", {31'd0, rx_overflow}, 32'd0);

        do_in(5'd24, 32'h00ABCDEF);
        idle_inputs();
        push_op = 1'b1; push_iffull = 1'b1; thresh = 5'd0;
        apply_stimulus();
        check_output("iffull_noop_isr", dout, 32'h00ABCDEF);
        check_output("iffull_noop_count", {26'd0, shift_count}, 32'd24);

        do_set(32'd0);
        do_in(5'd10, 32'h3FF);
        do_set(32'h55AA);
        check_output("set_dout", dout, 32'h55AA);
        check_output("set_count", {26'd0, shift_count}, 32'd0);

        idle_inputs();
        #2;
        reset = 1'b1;
        #1;
        check_output("async_reset_valid", {31'd0, push_valid}, 32'd0);
        check_output("async_reset_dout", dout, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 600; i++) begin
            int r;
            idle_inputs();
            penable     = ($urandom % 4) != 0;
            restart     = ($urandom % 32) == 0;
            set         = ($urandom % 16) == 0;
            r           = $urandom % 8;
            in_op       = (r < 4) || (r == 6);
            push_op     = (r == 4) || (r == 5) || (r == 6);
            in_data     = $urandom;
            din         = $urandom;
            shift       = 5'($urandom);
            dir         = 1'($urandom);
            autopush    = 1'($urandom);
            thresh      = 5'($urandom);
            push_iffull = 1'($urandom);
            push_block  = 1'($urandom);
            push_ready  = ($urandom % 3) != 0;
            apply_stimulus();
        end

        idle_inputs();
        push_ready = 1'b1;
        repeat (3) apply_stimulus();
        check_output("scoreboard_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/isr.md
Name: isr

Overview:
- PIO state-machine input shift register: the receive-direction counterpart of the output shift register.
- Shifts pin/source bits in on IN, loads on MOV ISR, and pushes completed words to the RX FIFO.
- Pushes happen by explicit PUSH or by autopush at a threshold.
- Owns a one-entry push holding register, a valid/ready handshake toward the RX FIFO, and generates the state machine's stall.

Parameters:
- none; datapath fixed at 32 bits.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- penable  in  1  state-machine clock enable (instruction-side updates only)
- restart  in  1  SM restart strobe
- in_op  in  1  execute IN this cycle
- in_data  in  32  IN source; low n bits used
- shift  in  5  IN bit count n; 0 means 32
- dir  in  1  0 shift left, 1 shift right
- autopush  in  1  autopush enable
- thresh  in  5  push threshold; 0 means 32
- push_op  in  1  execute PUSH this cycle
- push_iffull  in  1  PUSH only if count >= threshold
- push_block  in  1  PUSH stalls when FIFO slot busy; 0 means drop
- set  in  1  MOV ISR load
- din  in  32  MOV source
- push_valid  out  1  holding register valid, toward RX FIFO
- push_data  out  32  holding register word
- push_ready  in  1  RX FIFO accepts this cycle
- stall  out  1  instruction cannot complete; SM repeats it
- rx_overflow  out  1  one-cycle pulse on dropped non-blocking PUSH
- dout  out  32  current ISR value (MOV source)
- shift_count  out  6  bits shifted in since last clear, 0..32

Behaviour:
- Reset (asynchronous): isr=0, count=0, push_valid=0, push_data=0, rx_overflow=0.
- Priority: reset > restart > set > (in_op | push_op). in_op and push_op are never both high; if they are, in_op wins.
- restart (no penable needed): count=0; isr unchanged; holding register unchanged.
- Instruction-side updates require penable=1 and stall=0. Holding-register drain ignores penable.
- Drain: if push_valid && push_ready, push_valid clears next cycle unless it is reloaded the same cycle.
- slot_free = !push_valid || push_ready.
- Shift (n = shift==0 ? 32 : shift):
  - left: isr' = (isr << n) | in_data[n-1:0]
  - right: isr' = {in_data[n-1:0], isr} >> n, bits enter at MSB
  - count' = min(count+n, 32)
- set: isr=din, count=0.
- Autopush on IN, thr = thresh==0 ? 32 : thresh: if autopush && count' >= thr:
  - slot_free: push_data <= isr', push_valid <= 1, isr <= 0, count <= 0.
  - else: stall=1, no state change.
- Explicit PUSH, eligible = !push_iffull || count >= thr:
  - not eligible: no-op.
  - eligible and slot_free: push_data <= isr, push_valid <= 1, isr <= 0, count <= 0.
  - eligible, !slot_free, push_block=1: stall=1, no change.
  - eligible, !slot_free, push_block=0: isr <= 0, count <= 0, word dropped, rx_overflow pulses 1 cycle.
- stall is combinational from the current inputs and state. It is 0 when penable=0 or when reset/restart/set is active.
- Effective state: two states, EMPTY (push_valid=0) and FULL (push_valid=1).
  - EMPTY -> FULL on a push load.
  - FULL -> EMPTY on drain with no reload.
  - Simultaneous drain and reload stays FULL with the new data (no bubble).
- dout = isr (registered, not bypassed). shift_count = count.
- Reset mid-stall: everything clears immediately; a pending word in the holding register is lost.

Decomposition:
- Shared pio package: ISR_WIDTH=32 and a count_decode function (0 -> 32), shared with the OSR and autopull logic.
- One sub-module, isr_shifter: combinational; takes isr, in_data, n, dir and produces isr' and count'.

Test Plan:
- Reset, then IN left n=8 with in_data=0xA5, then n=8 with 0x3C, autopush off -> dout=0x0000A53C, shift_count=16.
- dir=1, IN n=4 with 0xF, repeated 8 times -> dout=0xFFFFFFFF, count=32, saturating at 32 on a 9th IN.
- autopush thresh=16, push_ready=1, two IN n=8 (0x12, 0x34) -> push_valid=1, push_data=0x1234 after the 2nd IN, isr=0, count=0.
- push_ready=0, holding register full, IN triggers autopush -> stall=1, isr/count unchanged. Raise push_ready -> same cycle: stall=0, holding register reloads, push_valid stays 1.
- push_ready=0, holding register full, PUSH noblock with isr=0xDEADBEEF -> rx_overflow=1 for 1 cycle, isr=0, push_data unchanged.
- PUSH iffull, thresh=0 (32), count=24 -> no-op. set din=0x55AA with count=10 -> dout=0x55AA, count=0. Assert reset while push_valid=1 -> push_valid=0 without waiting for a clock edge.
